// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller slice.
package hazard_pkg;
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 16;
  localparam logic [4:0]  REG_ZERO    = 5'd0;

  // Counter preload: the entry cycle already counts as one stall cycle.
  function automatic logic [7:0] md_load_val(input int unsigned lat);
    return 8'(lat - 1);
  endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master = pipeline, slave = controller.
interface hazard_stall_ctrl_if;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rt_i;
  logic        md_start_i;
  logic        md_is_div_i;
  logic        branch_taken_i;
  logic        pc_write_disable_o;
  logic        ifid_write_disable_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        exmem_flush_o;
  logic        md_busy_o;
  logic        md_done_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           md_start_i, md_is_div_i, branch_taken_i,
    input  pc_write_disable_o, ifid_write_disable_o, ifid_flush_o,
           idex_flush_o, exmem_flush_o, md_busy_o, md_done_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           md_start_i, md_is_div_i, branch_taken_i,
    output pc_write_disable_o, ifid_write_disable_o, ifid_flush_o,
           idex_flush_o, exmem_flush_o, md_busy_o, md_done_o, stall_cnt_o
  );
endinterface

// File: rtl/md_latency_counter.sv
// 8-bit loadable down-counter tracking remaining mult/div occupancy.
module md_latency_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);
  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                       cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 8'd1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mult-div stall and branch flush controller.
// Optional saturating stall-cycle counter: define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.slave  hz
);
  md_state_e state_q, state_nxt;
  logic      lu;
  logic      cnt_load, cnt_dec, cnt_zero;
  logic      pc_wd, ifid_wd, ifid_fl, idex_fl, exmem_fl, busy, done;

  assign lu = hz.ex_memread_i && (hz.ex_rt_i != REG_ZERO) &&
              ((hz.ex_rt_i == hz.id_rs_i) ||
               (hz.id_uses_rt_i && (hz.ex_rt_i == hz.id_rt_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_nxt;
  end

  // Priority: branch > MD_BUSY > load-use > md_start; reset silences everything.
  always_comb begin
    state_nxt = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    pc_wd     = 1'b0;
    ifid_wd   = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    exmem_fl  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!rst_i) begin
      busy = (state_q == ST_MD_BUSY);
      if (hz.branch_taken_i) begin
        ifid_fl   = 1'b1;
        idex_fl   = 1'b1;
        exmem_fl  = 1'b1;
        state_nxt = ST_RUN;
      end else begin
        unique case (state_q)
          ST_MD_BUSY: begin
            if (cnt_zero) begin
              done      = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              pc_wd   = 1'b1;
              ifid_wd = 1'b1;
              idex_fl = 1'b1;
              cnt_dec = 1'b1;
            end
          end
          default: begin
            if (lu) begin
              pc_wd   = 1'b1;
              ifid_wd = 1'b1;
              idex_fl = 1'b1;
            end else if (hz.md_start_i) begin
              pc_wd     = 1'b1;
              ifid_wd   = 1'b1;
              idex_fl   = 1'b1;
              cnt_load  = 1'b1;
              state_nxt = ST_MD_BUSY;
            end
          end
        endcase
      end
    end
  end

  md_latency_counter u_md_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (hz.md_is_div_i ? md_load_val(DIV_LAT) : md_load_val(MUL_LAT)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign hz.pc_write_disable_o   = pc_wd;
  assign hz.ifid_write_disable_o = ifid_wd;
  assign hz.ifid_flush_o         = ifid_fl;
  assign hz.idex_flush_o         = idex_fl;
  assign hz.exmem_flush_o        = exmem_fl;
  assign hz.md_busy_o            = busy;
  assign hz.md_done_o            = done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                             stall_cnt_q <= '0;
    else if (pc_wd && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall_cnt_o = rst_i ? '0 : stall_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl against a cycle-count reference model.
module tb_hazard_stall_ctrl;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // Model state: cycles until the done pulse (0 = idle), and stall tally.
  int          md_left  = 0;
  logic [31:0] perf_exp = '0;

  hazard_stall_ctrl_if hif ();

  hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  task automatic idle();
    hif.id_rs_i = 5'd0; hif.id_rt_i = 5'd0; hif.id_uses_rt_i = 1'b0;
    hif.ex_memread_i = 1'b0; hif.ex_rt_i = 5'd0;
    hif.md_start_i = 1'b0; hif.md_is_div_i = 1'b0; hif.branch_taken_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluate current inputs against the model, then advance one clock.
  task automatic tick(input string tag);
    logic lu, stall;
    logic [6:0] exp_v, obs_v;
    #1;
    lu = hif.ex_memread_i && hif.ex_rt_i != 0 &&
         (hif.ex_rt_i == hif.id_rs_i || (hif.id_uses_rt_i && hif.ex_rt_i == hif.id_rt_i));
    exp_v = '0;
    stall = 1'b0;
    if (!rst) begin
      exp_v[1] = (md_left > 0);
      if (hif.branch_taken_i)      exp_v[4:2] = 3'b111;
      else if (md_left == 1)       exp_v[0] = 1'b1;
      else if (md_left > 1)        stall = 1'b1;
      else if (lu || hif.md_start_i) stall = 1'b1;
      if (stall) begin
        exp_v[6] = 1'b1; exp_v[5] = 1'b1; exp_v[3] = 1'b1;
      end
    end
    obs_v = {hif.pc_write_disable_o, hif.ifid_write_disable_o, hif.ifid_flush_o,
             hif.idex_flush_o, hif.exmem_flush_o, hif.md_busy_o, hif.md_done_o};
    check({tag, ".ctrl"}, 32'(obs_v), 32'(exp_v));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, ".stall_cnt"}, hif.stall_cnt_o, rst ? 32'd0 : perf_exp);
`else
    check({tag, ".stall_cnt"}, hif.stall_cnt_o, 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      md_left = 0; perf_exp = '0;
    end else begin
      if (exp_v[6] && perf_exp != '1) perf_exp = perf_exp + 1;
      if (hif.branch_taken_i)         md_left = 0;
      else if (md_left > 0)           md_left = md_left - 1;
      else if (!lu && hif.md_start_i) md_left = hif.md_is_div_i ? DIV_LAT : MUL_LAT;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    // Reset holds outputs low regardless of inputs.
    hif.ex_memread_i = 1'b1; hif.ex_rt_i = 5'd3; hif.id_rs_i = 5'd3;
    hif.branch_taken_i = 1'b1; hif.md_start_i = 1'b1;
    tick("reset0");
    idle();
    tick("reset1");
    rst = 1'b0;
    tick("run_idle");

    // Load-use on rs: one stall cycle only.
    hif.ex_memread_i = 1'b1; hif.ex_rt_i = 5'd8; hif.id_rs_i = 5'd8;
    tick("lu_rs");
    idle();
    tick("lu_rs_after");
    // $zero destination never stalls.
    hif.ex_memread_i = 1'b1;
    tick("lu_zero");
    // rt match only counts when rt is a source.
    hif.ex_rt_i = 5'd9; hif.id_rt_i = 5'd9; hif.id_rs_i = 5'd1;
    tick("rt_unused");
    hif.id_uses_rt_i = 1'b1;
    tick("rt_used");
    // Load-use beats md_start the same cycle.
    hif.md_start_i = 1'b1;
    tick("lu_vs_start");
    idle();

    // Multiply with md_start held through the busy period.
    hif.md_start_i = 1'b1;
    for (int i = 0; i < 4; i++) tick("mul_held");
    idle();
    for (int i = 0; i < 2; i++) tick("mul_tail");

    // Divide aborted by a branch when the hardware counter reads 7.
    hif.md_start_i = 1'b1; hif.md_is_div_i = 1'b1;
    tick("div_start");
    idle();
    for (int i = 0; i < 8; i++) tick("div_busy");
    check("div_cnt7_model", 32'(md_left), 32'd8);
    hif.branch_taken_i = 1'b1;
    tick("div_branch");
    idle();
    for (int i = 0; i < 3; i++) tick("div_after");

    // Load-use and branch together: flushes only.
    hif.ex_memread_i = 1'b1; hif.ex_rt_i = 5'd5; hif.id_rs_i = 5'd5;
    hif.branch_taken_i = 1'b1;
    tick("lu_branch");
    idle();

    // Reset mid-multiply.
    hif.md_start_i = 1'b1;
    tick("mul_start2");
    idle();
    tick("mul_busy2");
    rst = 1'b1;
    tick("mul_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("post_reset");

    // Randomized traffic with narrow register range to provoke hazards.
    for (int n = 0; n < 500; n++) begin
      rst                = ($urandom_range(0, 39) == 0);
      hif.id_rs_i        = 5'($urandom_range(0, 3));
      hif.id_rt_i        = 5'($urandom_range(0, 3));
      hif.id_uses_rt_i   = 1'($urandom_range(0, 1));
      hif.ex_memread_i   = ($urandom_range(0, 2) == 0);
      hif.ex_rt_i        = 5'($urandom_range(0, 3));
      hif.md_start_i     = ($urandom_range(0, 4) == 0);
      hif.md_is_div_i    = 1'($urandom_range(0, 1));
      hif.branch_taken_i = ($urandom_range(0, 11) == 0);
      tick("rand");
    end
    rst = 1'b0;
    idle();

    // One load-use plus one multiply accumulate five stall cycles.
    rst = 1'b1;
    tick("perf_rst");
    rst = 1'b0;
    hif.ex_memread_i = 1'b1; hif.ex_rt_i = 5'd8; hif.id_rs_i = 5'd8;
    tick("perf_lu");
    idle();
    hif.md_start_i = 1'b1;
    tick("perf_mul");
    idle();
    for (int i = 0; i < 6; i++) tick("perf_run");
    #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_total", hif.stall_cnt_o, 32'd5);
`else
    check("perf_total", hif.stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick("perf_clear");
    rst = 1'b0;
    tick("perf_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
